simplified_sha256: RTL and testbench
====================================

Name: simplified_sha256

Overview:
Memory-mapped SHA-256 co-processor. On start it reads a NUM_OF_WORDS-word message from a single-port 32-bit word memory beginning at input_addr, and pads the message internally. It hashes every 512-bit block and writes the 8-word digest H0..H7 to hash_addr..hash_addr+7. It then pulses done.

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words (1..255); bit length = NUM_OF_WORDS*32.

Ports:
clk  in  1  system clock; only clock.
rst_n  in  1  synchronous active-low reset.
start  in  1  level request; sampled only in IDLE.
input_addr  in  16  word address of message word 0.
hash_addr  in  16  word address of digest word H0.
memory_read_data  in  32  read data from memory, registered by memory one cycle after address.
done  out  1  one-cycle completion pulse.
memory_clk  out  1  memory clock; equal to clk.
enable_write  out  1  1 = write memory_write_data to memory_addr at next memory_clk rise; 0 = read.
memory_addr  out  16  word address.
memory_write_data  out  32  write data.
current_state_  out  3  debug: FSM state code.
round_index_  out  8  debug: current round / word counter.
hash0_  out  32  debug: H0 register.
A_  out  32  debug: working variable a.

Behaviour:
- Reset (rst_n=0 at clk rise): state IDLE. done=0, enable_write=0, memory_addr=0, memory_write_data=0, round_index_=0. H0..H7 and a..h load the SHA-256 IVs (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19). Reset mid-operation aborts with no further writes.
- Block count NB = (NUM_OF_WORDS+2)/16 + 1 (integer division). The padded word stream P has length NB*16:
  - P[i] = mem[input_addr+i] for i < NUM_OF_WORDS.
  - P[NUM_OF_WORDS] = 80000000.
  - P[NB*16-1] = NUM_OF_WORDS*32.
  - Every other word is 0.
- Padding words are generated internally. Memory is read only for i < NUM_OF_WORDS.
- State codes: IDLE=0, READ=1, COMPUTE=2, UPDATE=3, WRITE=4, DONE=5.
- IDLE: enable_write=0. If start=1, load a..h from IV and H0..H7 from IV, clear the block counter, and go to READ. A start held for several cycles starts only one run.
- READ: fetch the 16 words of the current block into W[0..15].
  - Read latency is one cycle: data for the address driven in cycle n is captured in cycle n+2 relative to the address register update.
  - Address = input_addr + block*16 + j.
  - Then go to COMPUTE with round_index_=0.
- COMPUTE: one round per clock, t = 0..63.
  - W[t] for t ≥ 16 = W[t-16] + σ0(W[t-15]) + W[t-7] + σ1(W[t-2]), computed with a 16-entry sliding window.
  - σ0 = rotr7 ^ rotr18 ^ shr3; σ1 = rotr17 ^ rotr19 ^ shr10.
  - Round update: T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = Σ0(a) + Maj(a,b,c); {a..h} ← {T1+T2, a, b, c, d+T1, e, f, g}.
  - Σ1 = rotr6 ^ rotr11 ^ rotr25; Σ0 = rotr2 ^ rotr13 ^ rotr22. K[t] are the standard SHA-256 constants.
  - All arithmetic is mod 2^32.
- UPDATE: Hi ← Hi + working var i, and a..h ← new Hi.
  - Increment block. If block < NB go to READ, else go to WRITE.
- WRITE: 8 consecutive cycles with enable_write=1, memory_addr = hash_addr+n, memory_write_data = Hn, n = 0..7. Then go to DONE.
- DONE: enable_write=0, done=1 for exactly one cycle. All 8 writes have completed at memory by then. Next state is IDLE.
- done is never asserted outside DONE. The memory is never written outside WRITE.
- round_index_ is 0 outside COMPUTE/READ.

Test Plan:
- NUM_OF_WORDS=1, mem[0]=61626364 ("abcd"), input_addr=0, hash_addr=1000, start high 2 cycles → mem[1000..1007] = 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589; exactly one done pulse; no writes outside 1000..1007.
- NUM_OF_WORDS=20, seed 01234675 with word[m] = rotl1(word[m-1]), input_addr=0, hash_addr=1000 → 2 blocks processed (round_index_ sweeps 0..63 twice); digest matches a software SHA-256 over the 640-bit message.
- Padding boundaries: NUM_OF_WORDS=13 gives 1 block; NUM_OF_WORDS=14 gives 2 blocks; digests match the software model in both cases.
- Reset asserted during COMPUTE → within one clock current_state_=0, done=0, enable_write=0; a subsequent start produces the correct digest.
- Back-to-back runs: second start after done with a different input_addr/hash_addr → second digest is correct and the first digest region is untouched.
- Reads never touch addresses ≥ input_addr+NUM_OF_WORDS (checked with a monitor on memory_addr while enable_write=0).

Source files
------------

// File: rtl/simplified_sha256.sv
// SHA-256 co-processor: fetches a NUM_OF_WORDS message from word memory, pads it
// on the fly, compresses each 512-bit block one round per clock and writes H0..H7 back.
module simplified_sha256 #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] input_addr,
    input  logic [15:0] hash_addr,
    input  logic [31:0] memory_read_data,
    output logic        done,
    output logic        memory_clk,
    output logic        enable_write,
    output logic [15:0] memory_addr,
    output logic [31:0] memory_write_data,
    output logic [2:0]  current_state_,
    output logic [7:0]  round_index_,
    output logic [31:0] hash0_,
    output logic [31:0] A_
);
    localparam int          NB      = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam logic [7:0]  NB_LAST = 8'(NB - 1);
    localparam logic [15:0] NW16    = 16'(NUM_OF_WORDS);
    localparam logic [31:0] BIT_LEN = 32'(NUM_OF_WORDS * 32);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        COMPUTE = 3'd2,
        UPDATE  = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 5'd3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 5'd10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    state_t      state_q;
    logic [7:0]  blk_q;
    logic [7:0]  idx_q;
    logic [2:0]  wr_cnt_q;
    logic [31:0] h_q    [8];
    logic [31:0] work_q [8];
    logic [31:0] w_q    [16];
    logic        done_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] t1_d;
    logic [31:0] t2_d;
    logic [31:0] w_new_d;
    logic [15:0] cap_i_d;
    logic [15:0] nxt_i_d;
    logic [15:0] nblk_i_d;
    logic [31:0] cap_word_d;
    logic [15:0] rd_addr_d;
    logic [15:0] entry_addr_d;
    logic [31:0] hsum_d [8];

    // Round datapath, schedule expansion, padded-word selection and read addressing.
    always_comb begin
        t1_d     = work_q[7] + bsig1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
                 + K[idx_q[5:0]] + w_q[0];
        t2_d     = bsig0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
        w_new_d  = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
        cap_i_d  = {4'd0, blk_q, 4'd0} + {8'd0, idx_q} - 16'd1;
        nxt_i_d  = {4'd0, blk_q, 4'd0} + {8'd0, idx_q} + 16'd1;
        nblk_i_d = {4'd0, blk_q + 8'd1, 4'd0};

        if (cap_i_d < NW16) begin
            cap_word_d = memory_read_data;
        end else if (cap_i_d == NW16) begin
            cap_word_d = 32'h8000_0000;
        end else if ((blk_q == NB_LAST) && (idx_q == 8'd16)) begin
            cap_word_d = BIT_LEN;
        end else begin
            cap_word_d = 32'd0;
        end

        // Beyond the message the address is held so reads never leave the message window.
        if (nxt_i_d < NW16) begin
            rd_addr_d = input_addr + nxt_i_d;
        end else begin
            rd_addr_d = addr_q;
        end

        if (nblk_i_d < NW16) begin
            entry_addr_d = input_addr + nblk_i_d;
        end else begin
            entry_addr_d = addr_q;
        end

        for (int i = 0; i < 8; i++) begin
            hsum_d[i] = h_q[i] + work_q[i];
        end
    end

    // Control FSM with registered memory interface and datapath state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            blk_q    <= 8'd0;
            idx_q    <= 8'd0;
            wr_cnt_q <= 3'd0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'd0;
            wdata_q  <= 32'd0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]    <= IV[i];
                work_q[i] <= IV[i];
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < 8; i++) begin
                            h_q[i]    <= IV[i];
                            work_q[i] <= IV[i];
                        end
                        blk_q   <= 8'd0;
                        idx_q   <= 8'd0;
                        addr_q  <= input_addr;
                        state_q <= READ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    if (idx_q != 8'd0) begin
                        for (int i = 0; i < 15; i++) begin
                            w_q[i] <= w_q[i+1];
                        end
                        w_q[15] <= cap_word_d;
                    end
                    if (idx_q == 8'd16) begin
                        idx_q   <= 8'd0;
                        state_q <= COMPUTE;
                    end else begin
                        idx_q  <= idx_q + 8'd1;
                        addr_q <= rd_addr_d;
                    end
                end
                COMPUTE: begin
                    for (int i = 0; i < 15; i++) begin
                        w_q[i] <= w_q[i+1];
                    end
                    w_q[15]   <= w_new_d;
                    work_q[0] <= t1_d + t2_d;
                    work_q[1] <= work_q[0];
                    work_q[2] <= work_q[1];
                    work_q[3] <= work_q[2];
                    work_q[4] <= work_q[3] + t1_d;
                    work_q[5] <= work_q[4];
                    work_q[6] <= work_q[5];
                    work_q[7] <= work_q[6];
                    if (idx_q == 8'd63) begin
                        idx_q   <= 8'd0;
                        state_q <= UPDATE;
                    end else begin
                        idx_q <= idx_q + 8'd1;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        h_q[i]    <= hsum_d[i];
                        work_q[i] <= hsum_d[i];
                    end
                    blk_q <= blk_q + 8'd1;
                    idx_q <= 8'd0;
                    if (blk_q != NB_LAST) begin
                        addr_q  <= entry_addr_d;
                        state_q <= READ;
                    end else begin
                        wr_cnt_q <= 3'd0;
                        we_q     <= 1'b1;
                        addr_q   <= hash_addr;
                        wdata_q  <= hsum_d[0];
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_cnt_q == 3'd7) begin
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wr_cnt_q <= wr_cnt_q + 3'd1;
                        addr_q   <= hash_addr + 16'(wr_cnt_q) + 16'd1;
                        wdata_q  <= h_q[wr_cnt_q + 3'd1];
                    end
                end
                DONE: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    idx_q   <= 8'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done              = done_q;
    assign memory_clk        = clk;
    assign enable_write      = we_q;
    assign memory_addr       = addr_q;
    assign memory_write_data = wdata_q;
    assign current_state_    = state_q;
    assign round_index_      = idx_q;
    assign hash0_            = h_q[0];
    assign A_                = work_q[0];
endmodule

// File: tb/tb_simplified_sha256.sv
// Directed bench: four engines (1, 13, 14 and 20 message words) sharing one word memory,
// with a behavioural SHA-256 model and bus monitors.
module tb_simplified_sha256;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] ABCD_DIGEST [8] = '{
        32'h88d4266f, 32'hd4e6338d, 32'h13b845fc, 32'hf289579d,
        32'h209c8978, 32'h23b9217d, 32'ha3e16193, 32'h6f031589
    };

    logic [3:0]  start_v;
    logic [15:0] in_addr_v [4];
    logic [15:0] h_addr_v  [4];
    logic [31:0] rdata;
    logic [3:0]  done_v;
    logic [3:0]  mclk_v;
    logic [3:0]  we_v;
    logic [15:0] maddr_v [4];
    logic [31:0] wdata_v [4];
    logic [2:0]  state_v [4];
    logic [7:0]  ridx_v  [4];
    logic [31:0] h0_v    [4];
    logic [31:0] a_v     [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        simplified_sha256 #(
            .NUM_OF_WORDS(g == 0 ? 1 : (g == 1 ? 13 : (g == 2 ? 14 : 20)))
        ) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .start             (start_v[g]),
            .input_addr        (in_addr_v[g]),
            .hash_addr         (h_addr_v[g]),
            .memory_read_data  (rdata),
            .done              (done_v[g]),
            .memory_clk        (mclk_v[g]),
            .enable_write      (we_v[g]),
            .memory_addr       (maddr_v[g]),
            .memory_write_data (wdata_v[g]),
            .current_state_    (state_v[g]),
            .round_index_      (ridx_v[g]),
            .hash0_            (h0_v[g]),
            .A_                (a_v[g])
        );
    end

    function automatic int nw_of(input int g);
        case (g)
            0:       return 1;
            1:       return 13;
            2:       return 14;
            default: return 20;
        endcase
    endfunction

    // Shared single-port memory with registered read; the bench preloads through its own port.
    logic [31:0] mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [31:0] tb_wdata;
    int          sel;
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        else if (we_v[sel]) mem[maddr_v[sel]] <= wdata_v[sel];
        rdata <= mem[maddr_v[sel]];
    end

    int checks = 0;
    int errors = 0;
    int done_cnt [4] = '{default: 0};
    int bad_wr = 0;
    int bad_done = 0;
    int bad_rd = 0;
    int r63_cnt = 0;

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (done_v[g]) begin
                done_cnt[g]++;
                if (state_v[g] != 3'd5) bad_done++;
            end
            if (we_v[g] && (g != sel || state_v[g] != 3'd4 || maddr_v[g] < h_addr_v[g] ||
                            maddr_v[g] > h_addr_v[g] + 16'd7)) bad_wr++;
        end
        if (state_v[sel] == 3'd1 && !we_v[sel] && (maddr_v[sel] < in_addr_v[sel] ||
            32'(maddr_v[sel]) >= 32'(in_addr_v[sel]) + 32'(nw_of(sel)))) bad_rd++;
        if (state_v[sel] == 3'd2 && ridx_v[sel] == 8'd63) r63_cnt++;
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_model(input logic [15:0] base, input int nw);
        logic [31:0] hh [8];
        logic [31:0] v  [8];
        logic [31:0] w  [64];
        logic [31:0] s0, s1, t1, t2;
        int nb, i;
        nb = (nw + 2) / 16 + 1;
        hh = IV;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 16; j++) begin
                i = b * 16 + j;
                if (i < nw) w[j] = mem[base + 16'(i)];
                else if (i == nw) w[j] = 32'h80000000;
                else if (i == nb * 16 - 1) w[j] = 32'(nw * 32);
                else w[j] = 32'd0;
            end
            for (int t = 16; t < 64; t++) begin
                s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
            v = hh;
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
                t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
                v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
            end
            for (int k = 0; k < 8; k++) hh[k] = hh[k] + v[k];
        end
        return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
    endfunction

    task automatic mem_wr(input logic [15:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic clear_region(input logic [15:0] a);
        for (int k = 0; k < 8; k++) mem_wr(a + 16'(k), 32'd0);
    endtask

    task automatic run_dut(input int g, input logic [15:0] ia, input logic [15:0] ha, input int hold);
        int cyc;
        sel = g; in_addr_v[g] = ia; h_addr_v[g] = ha;
        start_v[g] = 1'b1;
        repeat (hold) @(posedge clk);
        #1 start_v[g] = 1'b0;
        cyc = 0;
        while (!done_v[g] && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done_v[g]) begin
            errors++;
            $display("FAIL run_timeout dut%0d: done not seen after %0d cycles, expected within 3000", g, cyc);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (state_v[g] !== 3'd0 || done_v[g] !== 1'b0 || we_v[g] !== 1'b0 || maddr_v[g] !== 16'd0 ||
                wdata_v[g] !== 32'd0 || ridx_v[g] !== 8'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: state=%0d done=%b we=%b addr=%h wdata=%h ridx=%0d, expected all zero",
                         g, state_v[g], done_v[g], we_v[g], maddr_v[g], wdata_v[g], ridx_v[g]);
            end
            checks++;
            if (h0_v[g] !== 32'h6a09e667 || a_v[g] !== 32'h6a09e667) begin
                errors++;
                $display("FAIL reset_iv dut%0d: hash0=%h A=%h, expected 6a09e667", g, h0_v[g], a_v[g]);
            end
            checks++;
            if (mclk_v[g] !== clk) begin
                errors++;
                $display("FAIL memory_clk dut%0d: got %b, expected %b", g, mclk_v[g], clk);
            end
        end
    endtask

    task automatic test_abcd();
        int d0;
        clear_region(16'd1000);
        mem_wr(16'd0, 32'h61626364);
        d0 = done_cnt[0];
        run_dut(0, 16'd0, 16'd1000, 2);
        repeat (20) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mem[16'd1000 + 16'(k)] !== ABCD_DIGEST[k]) begin
                errors++;
                $display("FAIL abcd_digest[%0d]: got %h, expected %h", k, mem[16'd1000 + 16'(k)], ABCD_DIGEST[k]);
            end
        end
        checks++;
        if (done_cnt[0] - d0 != 1) begin
            errors++;
            $display("FAIL abcd_done_pulses: got %0d, expected 1", done_cnt[0] - d0);
        end
    endtask

    task automatic test_two_blocks();
        logic [31:0] w;
        logic [255:0] exp_d;
        int r0;
        w = 32'h01234675;
        for (int m = 0; m < 20; m++) begin
            mem_wr(16'(m), w);
            w = {w[30:0], w[31]};
        end
        clear_region(16'd1000);
        exp_d = sha_model(16'd0, 20);
        r0 = r63_cnt;
        run_dut(3, 16'd0, 16'd1000, 1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mem[16'd1000 + 16'(k)] !== exp_d[255 - 32*k -: 32]) begin
                errors++;
                $display("FAIL nw20_digest[%0d]: got %h, expected %h", k, mem[16'd1000 + 16'(k)], exp_d[255 - 32*k -: 32]);
            end
        end
        checks++;
        if (r63_cnt - r0 != 2) begin
            errors++;
            $display("FAIL nw20_blocks: got %0d round sweeps, expected 2", r63_cnt - r0);
        end
    endtask

    task automatic test_padding_boundary();
        logic [255:0] exp_d;
        logic [15:0] ha;
        int r0;
        for (int g = 1; g <= 2; g++) begin
            ha = (g == 1) ? 16'd1100 : 16'd1200;
            clear_region(ha);
            exp_d = sha_model(16'd0, nw_of(g));
            r0 = r63_cnt;
            run_dut(g, 16'd0, ha, 1);
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (mem[ha + 16'(k)] !== exp_d[255 - 32*k -: 32]) begin
                    errors++;
                    $display("FAIL pad_nw%0d_digest[%0d]: got %h, expected %h", nw_of(g), k, mem[ha + 16'(k)],
                             exp_d[255 - 32*k -: 32]);
                end
            end
            checks++;
            if (r63_cnt - r0 != g) begin
                errors++;
                $display("FAIL pad_nw%0d_blocks: got %0d, expected %0d", nw_of(g), r63_cnt - r0, g);
            end
        end
    endtask

    task automatic test_reset_mid_compute();
        logic [255:0] exp_d;
        logic [31:0] acc;
        int cyc;
        clear_region(16'd3000);
        exp_d = sha_model(16'd0, 20);
        sel = 3; in_addr_v[3] = 16'd0; h_addr_v[3] = 16'd3000;
        start_v[3] = 1'b1;
        @(posedge clk);
        #1 start_v[3] = 1'b0;
        cyc = 0;
        while (state_v[3] != 3'd2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (state_v[3] != 3'd2) begin
            errors++;
            $display("FAIL reach_compute: state=%0d, expected 2", state_v[3]);
        end
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (state_v[3] !== 3'd0 || done_v[3] !== 1'b0 || we_v[3] !== 1'b0 || ridx_v[3] !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: state=%0d done=%b we=%b ridx=%0d, expected 0 0 0 0",
                     state_v[3], done_v[3], we_v[3], ridx_v[3]);
        end
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        acc = 32'd0;
        for (int k = 0; k < 8; k++) acc = acc | mem[16'd3000 + 16'(k)];
        checks++;
        if (acc !== 32'd0) begin
            errors++;
            $display("FAIL abort_no_write: region OR=%h, expected 00000000", acc);
        end
        run_dut(3, 16'd0, 16'd3000, 1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mem[16'd3000 + 16'(k)] !== exp_d[255 - 32*k -: 32]) begin
                errors++;
                $display("FAIL rerun_digest[%0d]: got %h, expected %h", k, mem[16'd3000 + 16'(k)], exp_d[255 - 32*k -: 32]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp1, exp2;
        for (int m = 0; m < 13; m++) mem_wr(16'd400 + 16'(m), 32'hA5C30000 ^ (32'(m) * 32'h01010101));
        clear_region(16'd1300);
        clear_region(16'd1400);
        exp1 = sha_model(16'd0, 13);
        exp2 = sha_model(16'd400, 13);
        run_dut(1, 16'd0, 16'd1300, 1);
        run_dut(1, 16'd400, 16'd1400, 1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mem[16'd1400 + 16'(k)] !== exp2[255 - 32*k -: 32]) begin
                errors++;
                $display("FAIL b2b_second[%0d]: got %h, expected %h", k, mem[16'd1400 + 16'(k)], exp2[255 - 32*k -: 32]);
            end
            checks++;
            if (mem[16'd1300 + 16'(k)] !== exp1[255 - 32*k -: 32]) begin
                errors++;
                $display("FAIL b2b_first_kept[%0d]: got %h, expected %h", k, mem[16'd1300 + 16'(k)], exp1[255 - 32*k -: 32]);
            end
        end
    endtask

    task automatic test_monitors();
        checks++;
        if (bad_wr != 0) begin
            errors++;
            $display("FAIL write_monitor: %0d illegal writes, expected 0", bad_wr);
        end
        checks++;
        if (bad_rd != 0) begin
            errors++;
            $display("FAIL read_monitor: %0d out-of-window reads, expected 0", bad_rd);
        end
        checks++;
        if (bad_done != 0) begin
            errors++;
            $display("FAIL done_monitor: %0d done outside DONE, expected 0", bad_done);
        end
    endtask

    initial begin
        rst_n = 1'b0; start_v = 4'b0; tb_we = 1'b0; tb_addr = 16'd0; tb_wdata = 32'd0; sel = 0;
        for (int g = 0; g < 4; g++) begin
            in_addr_v[g] = 16'd0;
            h_addr_v[g]  = 16'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_abcd();
        test_two_blocks();
        test_padding_boundary();
        test_reset_mid_compute();
        test_back_to_back();
        test_monitors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
